// File: rtl/i2c_seq_pkg.sv
// Register map, IICMB command codes, response bit positions and the
// state/status encodings shared by the command sequencer and its WB engine.
package i2c_seq_pkg;

  localparam logic [1:0] ADR_CSR  = 2'd0;
  localparam logic [1:0] ADR_DPR  = 2'd1;
  localparam logic [1:0] ADR_CMDR = 2'd2;

  localparam logic [2:0] CMD_WAIT   = 3'b000;
  localparam logic [2:0] CMD_WRITE  = 3'b001;
  localparam logic [2:0] CMD_RWACK  = 3'b010;
  localparam logic [2:0] CMD_RWNACK = 3'b011;
  localparam logic [2:0] CMD_START  = 3'b100;
  localparam logic [2:0] CMD_STOP   = 3'b101;
  localparam logic [2:0] CMD_SETBUS = 3'b110;

  localparam int RSP_DON = 7;
  localparam int RSP_NAK = 6;
  localparam int RSP_AL  = 5;
  localparam int RSP_ERR = 4;

  // Core enable plus interrupt enable.
  localparam logic [7:0] CSR_ENABLE = 8'hC0;

  typedef enum logic [1:0] {
    ST_OK       = 2'd0,
    ST_NAK      = 2'd1,
    ST_ARB_LOST = 2'd2,
    ST_ERR      = 2'd3
  } status_t;

  typedef enum logic [3:0] {
    S_INIT, S_IDLE, S_SETBUS, S_START, S_ADDR, S_WR_DATA,
    S_RD_DATA, S_RD_DPR, S_STOP, S_WAIT_IRQ, S_FIN
  } state_t;

endpackage

// File: rtl/i2c_seq_wb_xfer.sv
// Single-transaction Wishbone master: a go pulse launches one access that is
// held until ack_i; ack pulses in the cycle cyc_o falls, with rdata valid.
module i2c_seq_wb_xfer #(
  parameter int WB_ADDR_WIDTH = 2,
  parameter int WB_DATA_WIDTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     go,
  input  logic                     we,
  input  logic [WB_ADDR_WIDTH-1:0] adr,
  input  logic [WB_DATA_WIDTH-1:0] wdata,
  output logic                     busy,
  output logic [WB_DATA_WIDTH-1:0] rdata,
  output logic                     ack,
  output logic                     cyc_o,
  output logic                     stb_o,
  output logic [WB_ADDR_WIDTH-1:0] adr_o,
  output logic                     we_o,
  output logic [WB_DATA_WIDTH-1:0] dat_o,
  input  logic                     ack_i,
  input  logic [WB_DATA_WIDTH-1:0] dat_i
);

  logic active;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      active <= 1'b0;
      adr_o  <= '0;
      we_o   <= 1'b0;
      dat_o  <= '0;
      rdata  <= '0;
      ack    <= 1'b0;
    end else begin
      ack <= 1'b0;
      if (active) begin
        if (ack_i) begin
          active <= 1'b0;
          we_o   <= 1'b0;
          rdata  <= dat_i;
          ack    <= 1'b1;
        end
      end else if (go) begin
        active <= 1'b1;
        adr_o  <= adr;
        we_o   <= we;
        dat_o  <= wdata;
      end
    end
  end

  // Gating with reset lets an in-flight cycle be abandoned immediately.
  assign cyc_o = active && !rst_i;
  assign stb_o = active && !rst_i;
  assign busy  = active;

endmodule

// File: rtl/i2c_wb_cmd_sequencer.sv
// Hardware replacement for the CPU driving iicmb_m_wb: turns one transfer
// request into the SETBUS/START/address/data/STOP command sequence.
module i2c_wb_cmd_sequencer #(
  parameter int WB_ADDR_WIDTH = 2,
  parameter int WB_DATA_WIDTH = 8,
  parameter int LEN_W         = 8,
  parameter int IRQ_TIMEOUT   = 65535
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  output logic                     cyc_o,
  output logic                     stb_o,
  input  logic                     ack_i,
  output logic [WB_ADDR_WIDTH-1:0] adr_o,
  output logic                     we_o,
  output logic [WB_DATA_WIDTH-1:0] dat_o,
  input  logic [WB_DATA_WIDTH-1:0] dat_i,
  input  logic                     irq_i,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [7:0]               req_bus_id,
  input  logic [6:0]               req_addr,
  input  logic                     req_rw,
  input  logic [LEN_W-1:0]         req_len,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [7:0]               wr_data,
  output logic                     rd_valid,
  output logic [7:0]               rd_data,
  output logic                     done,
  output logic [1:0]               status
);
  import i2c_seq_pkg::*;

  localparam int TMO_W = $clog2(IRQ_TIMEOUT + 1);

  state_t                   state;
  status_t                  status_r;
  logic                     reinit;
  logic                     pend;
  logic                     phase;
  logic                     cmd_out;
  logic [2:0]               cur_cmd;
  logic [LEN_W-1:0]         cnt;
  logic [TMO_W-1:0]         tmo;
  logic [7:0]               bus_id_r;
  logic [6:0]               addr_r;
  logic                     rw_r;

  logic                     x_go;
  logic                     x_we;
  logic [WB_ADDR_WIDTH-1:0] x_adr;
  logic [WB_DATA_WIDTH-1:0] x_wdata;
  logic                     x_busy;
  logic [WB_DATA_WIDTH-1:0] x_rdata;
  logic                     x_ack;
  logic                     can_issue;

  logic                     need_dpr;
  logic [WB_DATA_WIDTH-1:0] dpr_val;
  logic [2:0]               cmd_val;

  i2c_seq_wb_xfer #(
    .WB_ADDR_WIDTH(WB_ADDR_WIDTH),
    .WB_DATA_WIDTH(WB_DATA_WIDTH)
  ) u_xfer (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .go    (x_go),
    .we    (x_we),
    .adr   (x_adr),
    .wdata (x_wdata),
    .busy  (x_busy),
    .rdata (x_rdata),
    .ack   (x_ack),
    .cyc_o (cyc_o),
    .stb_o (stb_o),
    .adr_o (adr_o),
    .we_o  (we_o),
    .dat_o (dat_o),
    .ack_i (ack_i),
    .dat_i (dat_i)
  );

  assign can_issue = !pend && !x_busy;

  // Per-state operands: optional DPR preload followed by the CMDR command.
  always_comb begin
    need_dpr = 1'b0;
    dpr_val  = '0;
    cmd_val  = CMD_STOP;
    case (state)
      S_SETBUS: begin
        need_dpr = 1'b1;
        dpr_val  = WB_DATA_WIDTH'(bus_id_r);
        cmd_val  = CMD_SETBUS;
      end
      S_START: cmd_val = CMD_START;
      S_ADDR: begin
        need_dpr = 1'b1;
        dpr_val  = WB_DATA_WIDTH'({addr_r, rw_r});
        cmd_val  = CMD_WRITE;
      end
      S_WR_DATA: begin
        need_dpr = 1'b1;
        dpr_val  = WB_DATA_WIDTH'(wr_data);
        cmd_val  = CMD_WRITE;
      end
      S_RD_DATA: cmd_val = (cnt == LEN_W'(1)) ? CMD_RWNACK : CMD_RWACK;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= S_INIT;
      status_r  <= ST_OK;
      reinit    <= 1'b0;
      pend      <= 1'b0;
      phase     <= 1'b0;
      cmd_out   <= 1'b0;
      cur_cmd   <= CMD_WAIT;
      cnt       <= '0;
      tmo       <= '0;
      bus_id_r  <= '0;
      addr_r    <= '0;
      rw_r      <= 1'b0;
      x_go      <= 1'b0;
      x_we      <= 1'b0;
      x_adr     <= '0;
      x_wdata   <= '0;
      req_ready <= 1'b0;
      wr_ready  <= 1'b0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
      done      <= 1'b0;
      status    <= ST_OK;
    end else begin
      x_go     <= 1'b0;
      wr_ready <= 1'b0;
      rd_valid <= 1'b0;
      done     <= 1'b0;
      case (state)
        S_INIT: begin
          if (can_issue) begin
            x_go    <= 1'b1;
            x_we    <= 1'b1;
            x_adr   <= WB_ADDR_WIDTH'(ADR_CSR);
            x_wdata <= WB_DATA_WIDTH'(CSR_ENABLE);
            pend    <= 1'b1;
          end else if (x_ack) begin
            pend      <= 1'b0;
            req_ready <= 1'b1;
            state     <= S_IDLE;
          end
        end
        S_IDLE: begin
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            bus_id_r  <= req_bus_id;
            addr_r    <= req_addr;
            rw_r      <= req_rw;
            cnt       <= req_len;
            status_r  <= ST_OK;
            reinit    <= 1'b0;
            phase     <= 1'b0;
            state     <= S_SETBUS;
          end
        end
        S_SETBUS, S_START, S_ADDR, S_WR_DATA, S_RD_DATA, S_STOP: begin
          if (can_issue) begin
            if (need_dpr && !phase) begin
              if (state != S_WR_DATA || wr_valid) begin
                x_go    <= 1'b1;
                x_we    <= 1'b1;
                x_adr   <= WB_ADDR_WIDTH'(ADR_DPR);
                x_wdata <= dpr_val;
                pend    <= 1'b1;
                if (state == S_WR_DATA) begin
                  wr_ready <= 1'b1;
                  cnt      <= cnt - LEN_W'(1);
                end
              end
            end else begin
              x_go    <= 1'b1;
              x_we    <= 1'b1;
              x_adr   <= WB_ADDR_WIDTH'(ADR_CMDR);
              x_wdata <= WB_DATA_WIDTH'(cmd_val);
              cur_cmd <= cmd_val;
              cmd_out <= 1'b1;
              pend    <= 1'b1;
            end
          end else if (x_ack) begin
            pend <= 1'b0;
            if (cmd_out) begin
              cmd_out <= 1'b0;
              phase   <= 1'b0;
              tmo     <= TMO_W'(IRQ_TIMEOUT);
              state   <= S_WAIT_IRQ;
            end else begin
              phase <= 1'b1;
            end
          end
        end
        S_WAIT_IRQ: begin
          if (can_issue) begin
            if (irq_i) begin
              x_go  <= 1'b1;
              x_we  <= 1'b0;
              x_adr <= WB_ADDR_WIDTH'(ADR_CMDR);
              pend  <= 1'b1;
            end else if (tmo == '0) begin
              status_r <= ST_ERR;
              reinit   <= 1'b1;
              state    <= S_FIN;
            end else begin
              tmo <= tmo - TMO_W'(1);
            end
          end else if (x_ack) begin
            pend <= 1'b0;
            // Lost arbitration leaves the controller idle, so no STOP follows.
            if (x_rdata[RSP_AL]) begin
              status_r <= ST_ARB_LOST;
              state    <= S_FIN;
            end else if (x_rdata[RSP_ERR] || (!x_rdata[RSP_DON] && !x_rdata[RSP_NAK])) begin
              status_r <= ST_ERR;
              reinit   <= 1'b1;
              state    <= S_FIN;
            end else if (x_rdata[RSP_NAK] && cur_cmd == CMD_WRITE) begin
              status_r <= ST_NAK;
              state    <= S_STOP;
            end else begin
              case (cur_cmd)
                CMD_SETBUS: state <= S_START;
                CMD_START:  state <= S_ADDR;
                CMD_WRITE:  state <= (cnt == '0) ? S_STOP : (rw_r ? S_RD_DATA : S_WR_DATA);
                CMD_RWACK, CMD_RWNACK: state <= S_RD_DPR;
                default:    state <= S_FIN;
              endcase
            end
          end
        end
        S_RD_DPR: begin
          if (can_issue) begin
            x_go  <= 1'b1;
            x_we  <= 1'b0;
            x_adr <= WB_ADDR_WIDTH'(ADR_DPR);
            pend  <= 1'b1;
          end else if (x_ack) begin
            pend     <= 1'b0;
            rd_valid <= 1'b1;
            rd_data  <= x_rdata[7:0];
            cnt      <= cnt - LEN_W'(1);
            state    <= (cnt == LEN_W'(1)) ? S_STOP : S_RD_DATA;
          end
        end
        S_FIN: begin
          done   <= 1'b1;
          status <= status_r;
          if (reinit) begin
            state <= S_INIT;
          end else begin
            req_ready <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_wb_cmd_sequencer.sv
// Self-checking bench: behavioural IICMB + I2C slave responder, randomized
// transfers, and a transfer-level reference model of the expected commands.
module tb_i2c_wb_cmd_sequencer;

  localparam logic [2:0] C_WRITE  = 3'b001;
  localparam logic [2:0] C_RWACK  = 3'b010;
  localparam logic [2:0] C_RWNACK = 3'b011;
  localparam logic [2:0] C_START  = 3'b100;
  localparam logic [2:0] C_STOP   = 3'b101;
  localparam logic [2:0] C_SETBUS = 3'b110;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       cyc_o, stb_o, ack_i, we_o;
  logic [1:0] adr_o;
  logic [7:0] dat_o, dat_i;
  logic       irq_i;
  logic       req_valid, req_ready, req_rw;
  logic [7:0] req_bus_id, req_len;
  logic [6:0] req_addr;
  logic       wr_valid, wr_ready, rd_valid, done;
  logic [7:0] wr_data, rd_data;
  logic [1:0] status;

  int checks = 0;
  int failures = 0;
  int cycle_no = 0;
  int done_count = 0;

  logic [6:0] slave_addr = 7'h39;
  bit         hold_irq = 0;
  bit         force_al = 0;
  bit         addr_phase = 0;
  logic [7:0] dpr_reg, rsp_reg;
  int         irq_wait = 0;
  int         lat = 0;
  logic [2:0] cmd_log[$];
  logic [7:0] slave_wr[$];
  logic [7:0] slave_rd[$];
  int         slave_rd_idx = 0;
  logic [7:0] seen_bus, seen_addr_byte;
  int         csr_writes = 0;
  logic [7:0] last_csr;
  int         last_cmd_cycle = 0;
  bit         first_seen = 0;
  logic [1:0] first_adr;
  logic       first_we;
  logic [7:0] first_dat;
  int         first_ack_cycle = 0;

  logic [7:0] tx_bytes[$];
  logic [7:0] obs_rd[$];
  bit         obs_done;
  logic [1:0] obs_status;
  int         obs_wr_pulses;
  int         obs_done_cycle;

  i2c_wb_cmd_sequencer #(
    .WB_ADDR_WIDTH(2),
    .WB_DATA_WIDTH(8),
    .LEN_W(8),
    .IRQ_TIMEOUT(100)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cyc_o(cyc_o), .stb_o(stb_o), .ack_i(ack_i), .adr_o(adr_o),
    .we_o(we_o), .dat_o(dat_o), .dat_i(dat_i), .irq_i(irq_i),
    .req_valid(req_valid), .req_ready(req_ready), .req_bus_id(req_bus_id),
    .req_addr(req_addr), .req_rw(req_rw), .req_len(req_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_data(rd_data), .done(done), .status(status)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cycle_no++;
  always @(negedge clk_i) if (done === 1'b1) done_count++;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Behavioural IICMB controller plus a single slave at slave_addr.
  task automatic doCommand(input logic [2:0] cmd);
    logic [7:0] rsp;
    rsp = 8'h80;
    case (cmd)
      C_SETBUS: seen_bus = dpr_reg;
      C_START: begin
        addr_phase = 1;
        if (force_al) rsp = 8'h20;
      end
      C_WRITE: begin
        if (addr_phase) begin
          addr_phase = 0;
          seen_addr_byte = dpr_reg;
          if (dpr_reg[7:1] != slave_addr) rsp = 8'h40;
        end else begin
          slave_wr.push_back(dpr_reg);
        end
      end
      C_RWACK, C_RWNACK: begin
        dpr_reg = (slave_rd_idx < slave_rd.size()) ? slave_rd[slave_rd_idx] : 8'hFF;
        slave_rd_idx++;
      end
      default: ;
    endcase
    rsp_reg = rsp;
    if (!hold_irq) irq_wait = $urandom_range(2, 12);
  endtask

  task automatic serveAccess();
    if (!first_seen) begin
      first_seen = 1;
      first_adr = adr_o;
      first_we = we_o;
      first_dat = dat_o;
      first_ack_cycle = cycle_no;
    end
    dat_i = 8'h00;
    if (we_o) begin
      case (adr_o)
        2'd0: begin csr_writes++; last_csr = dat_o; end
        2'd1: dpr_reg = dat_o;
        2'd2: begin
          cmd_log.push_back(dat_o[2:0]);
          last_cmd_cycle = cycle_no;
          doCommand(dat_o[2:0]);
        end
        default: ;
      endcase
    end else begin
      case (adr_o)
        2'd1: dat_i = dpr_reg;
        2'd2: begin dat_i = rsp_reg; irq_i = 0; end
        default: ;
      endcase
    end
  endtask

  initial begin
    ack_i = 0;
    dat_i = 0;
    irq_i = 0;
    forever begin
      @(negedge clk_i);
      ack_i = 0;
      if (rst_i) begin
        irq_i = 0;
        irq_wait = 0;
        lat = 0;
        addr_phase = 0;
      end else begin
        if (irq_wait > 0) begin
          irq_wait--;
          if (irq_wait == 0) irq_i = 1;
        end
        if (cyc_o && stb_o) begin
          if (lat > 0) lat--;
          else begin
            ack_i = 1;
            serveAccess();
            lat = $urandom_range(0, 2);
          end
        end
      end
    end
  end

  // Runs one transfer; abort_at>0 stops collecting once that many bytes were read.
  task automatic applyStimulus(input logic [7:0] bus, input logic [6:0] addr, input bit rw,
                               input int len, input bit seq_data, input int abort_at);
    int wr_idx;
    int waited;
    tx_bytes.delete();
    slave_rd.delete();
    for (int i = 0; i < len; i++) begin
      tx_bytes.push_back(seq_data ? 8'(i) : 8'($urandom_range(0, 255)));
      slave_rd.push_back(seq_data ? 8'(100 + i) : 8'($urandom_range(0, 255)));
    end
    cmd_log.delete();
    slave_wr.delete();
    slave_rd_idx = 0;
    seen_bus = 8'hxx;
    seen_addr_byte = 8'hxx;
    obs_rd.delete();
    obs_done = 0;
    obs_status = 2'bxx;
    obs_wr_pulses = 0;
    wr_idx = 0;
    @(negedge clk_i);
    req_valid = 1;
    req_bus_id = bus;
    req_addr = addr;
    req_rw = rw;
    req_len = 8'(len);
    waited = 0;
    while (req_ready !== 1'b1 && waited < 300) begin
      @(negedge clk_i);
      waited++;
    end
    checkOutput("req_ready before accept", 32'(req_ready), 32'd1);
    @(negedge clk_i);
    req_valid = 0;
    for (int c = 0; c < 6000 && !obs_done; c++) begin
      wr_valid = (wr_idx < len) && ($urandom_range(0, 3) != 0);
      wr_data = (wr_idx < len) ? tx_bytes[wr_idx] : 8'h00;
      @(negedge clk_i);
      if (wr_ready === 1'b1) begin
        obs_wr_pulses++;
        wr_idx++;
      end
      if (rd_valid === 1'b1) obs_rd.push_back(rd_data);
      if (done === 1'b1) begin
        obs_done = 1;
        obs_status = status;
        obs_done_cycle = cycle_no;
      end
      if (abort_at > 0 && obs_rd.size() == abort_at) break;
    end
    wr_valid = 0;
  endtask

  // Reference model: expected command stream and data from the transfer rules.
  task automatic checkTransfer(input string tag, input logic [7:0] bus, input logic [6:0] addr,
                               input bit rw, input int len);
    logic [2:0] exp_cmds[$];
    bit present;
    int exp_status;
    int exp_pulses;
    present = (addr == slave_addr);
    exp_cmds.push_back(C_SETBUS);
    exp_cmds.push_back(C_START);
    if (force_al) begin
      exp_status = 2;
    end else begin
      exp_cmds.push_back(C_WRITE);
      if (present) begin
        for (int i = 0; i < len; i++)
          exp_cmds.push_back(!rw ? C_WRITE : ((i == len - 1) ? C_RWNACK : C_RWACK));
      end
      exp_cmds.push_back(C_STOP);
      exp_status = present ? 0 : 1;
    end
    exp_pulses = (present && !rw && !force_al) ? len : 0;
    checkOutput({tag, " done"}, 32'(obs_done), 32'd1);
    checkOutput({tag, " status"}, 32'(obs_status), 32'(exp_status));
    checkOutput({tag, " wr_ready pulses"}, 32'(obs_wr_pulses), 32'(exp_pulses));
    checkOutput({tag, " bus id"}, 32'(seen_bus), 32'(bus));
    if (!force_al) checkOutput({tag, " addr byte"}, 32'(seen_addr_byte), 32'({addr, rw}));
    checkOutput({tag, " cmd count"}, 32'(cmd_log.size()), 32'(exp_cmds.size()));
    for (int i = 0; i < exp_cmds.size() && i < cmd_log.size(); i++)
      checkOutput($sformatf("%s cmd%0d", tag, i), 32'(cmd_log[i]), 32'(exp_cmds[i]));
    checkOutput({tag, " slave wr count"}, 32'(slave_wr.size()), 32'(exp_pulses));
    for (int i = 0; i < slave_wr.size() && i < exp_pulses; i++)
      checkOutput($sformatf("%s wr%0d", tag, i), 32'(slave_wr[i]), 32'(tx_bytes[i]));
    checkOutput({tag, " rd count"}, 32'(obs_rd.size()),
                32'((present && rw && !force_al) ? len : 0));
    for (int i = 0; i < obs_rd.size() && i < slave_rd.size(); i++)
      checkOutput($sformatf("%s rd%0d", tag, i), 32'(obs_rd[i]), 32'(slave_rd[i]));
  endtask

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int waited;
    int csr_before;
    int done_before;
    logic [6:0] a;
    bit rw;
    int len;
    rst_i = 1;
    req_valid = 0; req_bus_id = 0; req_addr = 0; req_rw = 0; req_len = 0;
    wr_valid = 0; wr_data = 0;
    repeat (5) @(negedge clk_i);
    checkOutput("reset cyc_o", 32'(cyc_o), 32'd0);
    checkOutput("reset stb_o", 32'(stb_o), 32'd0);
    checkOutput("reset we_o", 32'(we_o), 32'd0);
    checkOutput("reset adr_o", 32'(adr_o), 32'd0);
    checkOutput("reset dat_o", 32'(dat_o), 32'd0);
    checkOutput("reset req_ready", 32'(req_ready), 32'd0);
    checkOutput("reset done", 32'(done), 32'd0);
    checkOutput("reset status", 32'(status), 32'd0);
    checkOutput("reset wr_ready", 32'(wr_ready), 32'd0);
    checkOutput("reset rd_valid", 32'(rd_valid), 32'd0);
    rst_i = 0;

    waited = 0;
    while (!first_seen && waited < 50) begin @(negedge clk_i); waited++; end
    checkOutput("first op seen", 32'(first_seen), 32'd1);
    checkOutput("first op adr", 32'(first_adr), 32'd0);
    checkOutput("first op we", 32'(first_we), 32'd1);
    checkOutput("first op data", 32'(first_dat), 32'hC0);
    waited = 0;
    while (req_ready !== 1'b1 && waited < 50) begin @(negedge clk_i); waited++; end
    checkOutput("req_ready within 10 of ack", 32'((cycle_no - first_ack_cycle) <= 10), 32'd1);

    applyStimulus(8'h00, 7'h39, 0, 32, 1, 0);
    checkTransfer("write32", 8'h00, 7'h39, 0, 32);
    applyStimulus(8'h00, 7'h39, 1, 32, 1, 0);
    checkTransfer("read32", 8'h00, 7'h39, 1, 32);
    applyStimulus(8'h01, 7'h22, 0, 4, 1, 0);
    checkTransfer("nak addr", 8'h01, 7'h22, 0, 4);
    applyStimulus(8'h02, 7'h39, 1, 0, 1, 0);
    checkTransfer("probe len0", 8'h02, 7'h39, 1, 0);
    force_al = 1;
    applyStimulus(8'h03, 7'h39, 0, 2, 1, 0);
    checkTransfer("arb lost", 8'h03, 7'h39, 0, 2);
    force_al = 0;

    for (int t = 0; t < 10; t++) begin
      a = ($urandom_range(0, 3) != 0) ? 7'h39 : (7'h39 ^ 7'($urandom_range(1, 127)));
      rw = 1'($urandom_range(0, 1));
      len = $urandom_range(0, 6);
      applyStimulus(8'($urandom_range(0, 255)), a, rw, len, 0, 0);
      checkTransfer($sformatf("rand%0d", t), req_bus_id, a, rw, len);
    end

    hold_irq = 1;
    csr_before = csr_writes;
    applyStimulus(8'h04, 7'h39, 0, 3, 1, 0);
    checkOutput("timeout done", 32'(obs_done), 32'd1);
    checkOutput("timeout status", 32'(obs_status), 32'd3);
    checkOutput("timeout cmd count", 32'(cmd_log.size()), 32'd1);
    checkOutput("timeout latency window",
                32'((obs_done_cycle - last_cmd_cycle) >= 95 && (obs_done_cycle - last_cmd_cycle) <= 115),
                32'd1);
    hold_irq = 0;
    waited = 0;
    while (req_ready !== 1'b1 && waited < 100) begin @(negedge clk_i); waited++; end
    checkOutput("timeout reinit csr writes", 32'(csr_writes), 32'(csr_before + 1));
    checkOutput("timeout reinit csr value", 32'(last_csr), 32'hC0);

    applyStimulus(8'h05, 7'h39, 1, 10, 1, 5);
    checkOutput("abort bytes read", 32'(obs_rd.size()), 32'd5);
    waited = 0;
    while (cyc_o !== 1'b1 && waited < 100) begin @(negedge clk_i); waited++; end
    checkOutput("abort cyc active", 32'(cyc_o), 32'd1);
    done_before = done_count;
    rst_i = 1;
    @(negedge clk_i);
    checkOutput("abort cyc dropped", 32'(cyc_o), 32'd0);
    repeat (3) @(negedge clk_i);
    rst_i = 0;
    repeat (3) @(negedge clk_i);
    checkOutput("abort no done", 32'(done_count), 32'(done_before));
    applyStimulus(8'h06, 7'h39, 0, 4, 0, 0);
    checkTransfer("after reset", 8'h06, 7'h39, 0, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
